// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: issues in-order word requests to instruction memory,
// buffers returned words in a small in-order queue, and presents the head entry
// to decode. A taken branch/jump from EX flushes the queue, reloads the PC and
// drops responses that are still in flight from the abandoned path.
module if_fetch_unit #(
    parameter int                        REG_DATA_WIDTH = 32,
    parameter logic [REG_DATA_WIDTH-1:0] PC_RESET       = '0,
    parameter int                        FIFO_DEPTH     = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    output logic                      IMEM_req,
    output logic [REG_DATA_WIDTH-1:0] IMEM_addr,
    input  logic                      IMEM_ready,
    input  logic                      IMEM_rvalid,
    input  logic [REG_DATA_WIDTH-1:0] IMEM_rdata,
    input  logic                      EX_branch_taken,
    input  logic [REG_DATA_WIDTH-1:0] EX_branch_target,
    input  logic                      ID_ready,
    output logic                      IF_valid,
    output logic [REG_DATA_WIDTH-1:0] IF_Instruction,
    output logic [REG_DATA_WIDTH-1:0] IF_PC
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [REG_DATA_WIDTH-1:0] NOP_INSTR = REG_DATA_WIDTH'(32'h0000_0013);
    localparam logic [CW-1:0]             DEPTH_C   = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                      state;
    state_t                      state_n;
    logic [REG_DATA_WIDTH-1:0]   pc;
    logic [REG_DATA_WIDTH-1:0]   buf_addr [FIFO_DEPTH];
    logic [REG_DATA_WIDTH-1:0]   buf_data [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0]       buf_full;
    logic [PW-1:0]               head;
    logic [PW-1:0]               tail;
    logic [PW-1:0]               fptr;
    logic [CW-1:0]               occ;
    logic [CW-1:0]               pending;
    logic [CW-1:0]               discard;
    logic [CW-1:0]               discard_n;
    logic [CW-1:0]               discard_base;
    logic [CW-1:0]               occ_after_pop;
    logic                        redirect;
    logic                        pop_raw;
    logic                        pop;
    logic                        accept;
    logic                        fill;
    logic                        drop;
    logic [REG_DATA_WIDTH-1:0]   target_aligned;

    assign target_aligned = EX_branch_target & ~REG_DATA_WIDTH'(3);

    // Head-of-queue presentation and request/handshake decode
    always_comb begin
        IF_valid       = buf_full[head];
        IF_Instruction = buf_data[head];
        IF_PC          = buf_addr[head];
        redirect       = EX_branch_taken && (state != S_BOOT);
        pop_raw        = IF_valid && ID_ready;
        pop            = pop_raw && !redirect;
        occ_after_pop  = occ - CW'(pop_raw);
        IMEM_req       = (state == S_RUN) && !EX_branch_taken && (occ_after_pop < DEPTH_C);
        IMEM_addr      = pc;
        accept         = IMEM_req && IMEM_ready;
        fill           = IMEM_rvalid && (pending != '0);
        drop           = IMEM_rvalid && (state == S_DRAIN) && (discard != '0);
    end

    // Discard count and next FSM state; a response arriving in the redirect
    // cycle is already one of the abandoned ones, so it is taken off the count
    always_comb begin
        discard_base = (state == S_DRAIN) ? discard : pending;
        discard_n    = discard;
        state_n      = state;
        if (redirect) begin
            discard_n = discard_base - CW'(IMEM_rvalid && (discard_base != '0));
            state_n   = (discard_n != '0) ? S_DRAIN : S_RUN;
        end else begin
            case (state)
                S_BOOT:  state_n = S_RUN;
                S_RUN:   state_n = S_RUN;
                S_DRAIN: begin
                    discard_n = discard - CW'(drop);
                    state_n   = (discard_n == '0) ? S_RUN : S_DRAIN;
                end
                default: state_n = S_BOOT;
            endcase
        end
    end

    // FSM state, PC, queue pointers and occupancy counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_BOOT;
            pc      <= PC_RESET;
            head    <= '0;
            tail    <= '0;
            fptr    <= '0;
            occ     <= '0;
            pending <= '0;
            discard <= '0;
        end else begin
            state   <= state_n;
            discard <= discard_n;
            if (redirect) begin
                pc      <= target_aligned;
                head    <= '0;
                tail    <= '0;
                fptr    <= '0;
                occ     <= '0;
                pending <= '0;
            end else begin
                if (accept) begin
                    pc   <= pc + REG_DATA_WIDTH'(4);
                    tail <= tail + PW'(1);
                end
                if (fill) begin
                    fptr <= fptr + PW'(1);
                end
                if (pop) begin
                    head <= head + PW'(1);
                end
                occ     <= occ + CW'(accept) - CW'(pop);
                pending <= pending + CW'(accept) - CW'(fill);
            end
        end
    end

    // Queue storage: address captured at accept, word and valid flag at fill
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_full <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                buf_addr[i] <= PC_RESET;
                buf_data[i] <= NOP_INSTR;
            end
        end else if (redirect) begin
            buf_full <= '0;
        end else begin
            if (pop) begin
                buf_full[head] <= 1'b0;
            end
            if (accept) begin
                buf_addr[tail] <= pc;
                buf_full[tail] <= 1'b0;
            end
            if (fill) begin
                buf_data[fptr] <= IMEM_rdata;
                buf_full[fptr] <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit with an in-order instruction memory model of
// selectable response latency.
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        IMEM_req;
    logic [31:0] IMEM_addr;
    logic        IMEM_ready;
    logic        IMEM_rvalid;
    logic [31:0] IMEM_rdata;
    logic        EX_branch_taken;
    logic [31:0] EX_branch_target;
    logic        ID_ready;
    logic        IF_valid;
    logic [31:0] IF_Instruction;
    logic [31:0] IF_PC;

    logic        w2_req;
    logic [31:0] w2_addr;
    logic        w2_valid;
    logic [31:0] w2_instr;
    logic [31:0] w2_pc;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    if_fetch_unit #(.REG_DATA_WIDTH(32), .PC_RESET(32'h0), .FIFO_DEPTH(2)) dut (
        .clk(clk), .rst(rst),
        .IMEM_req(IMEM_req), .IMEM_addr(IMEM_addr), .IMEM_ready(IMEM_ready),
        .IMEM_rvalid(IMEM_rvalid), .IMEM_rdata(IMEM_rdata),
        .EX_branch_taken(EX_branch_taken), .EX_branch_target(EX_branch_target),
        .ID_ready(ID_ready),
        .IF_valid(IF_valid), .IF_Instruction(IF_Instruction), .IF_PC(IF_PC)
    );

    if_fetch_unit #(.REG_DATA_WIDTH(32), .PC_RESET(32'hFFFF_FFFC), .FIFO_DEPTH(2)) dut2 (
        .clk(clk), .rst(rst),
        .IMEM_req(w2_req), .IMEM_addr(w2_addr), .IMEM_ready(IMEM_ready),
        .IMEM_rvalid(IMEM_rvalid), .IMEM_rdata(IMEM_rdata),
        .EX_branch_taken(EX_branch_taken), .EX_branch_target(EX_branch_target),
        .ID_ready(ID_ready),
        .IF_valid(w2_valid), .IF_Instruction(w2_instr), .IF_PC(w2_pc)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    typedef struct {
        logic [31:0] addr;
        int          due;
    } rsp_t;

    rsp_t q[$];
    int   cyc        = 0;
    int   lat        = 1;
    int   rst_epoch  = 0;
    int   seen_epoch = 0;

    // Memory model: responses in request order, lat cycles after accept
    always @(posedge clk) begin
        if (rst || rst_epoch != seen_epoch) begin
            q.delete();
            seen_epoch = rst_epoch;
        end else begin
            if (IMEM_rvalid && q.size() > 0) void'(q.pop_front());
            if (IMEM_req && IMEM_ready) q.push_back('{IMEM_addr, cyc + lat});
        end
        cyc++;
        #1;
        IMEM_rvalid = 1'b0;
        IMEM_rdata  = '0;
        if (q.size() > 0) begin
            if (q[0].due <= cyc) begin
                IMEM_rvalid = 1'b1;
                IMEM_rdata  = mem_word(q[0].addr);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        rst_epoch++;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Directed stimulus; cycle labels c0.. count from reset release (c0 = BOOT)
    initial begin
        IMEM_ready       = 1'b1;
        ID_ready         = 1'b1;
        EX_branch_taken  = 1'b0;
        EX_branch_target = '0;
        IMEM_rvalid      = 1'b0;
        IMEM_rdata       = '0;

        // reset values
        smp();
        chk("rst_req",   {31'b0, IMEM_req}, 32'd0);
        chk("rst_valid", {31'b0, IF_valid}, 32'd0);
        chk("rst_instr", IF_Instruction, 32'h0000_0013);
        chk("rst_pc",    IF_PC, 32'h0);
        chk("rst_pc2",   w2_pc, 32'hFFFF_FFFC);

        // 1: streaming, 1-cycle latency, no bubbles; dut2 shows address wrap
        do_reset();
        smp(); chk("t1_c0_req", {31'b0, IMEM_req}, 32'd0);
        nxt(); smp();
        chk("t1_c1_req",   {31'b0, IMEM_req}, 32'd1);
        chk("t1_c1_addr",  IMEM_addr, 32'h0);
        chk("t5_c1_addr2", w2_addr, 32'hFFFF_FFFC);
        nxt(); smp();
        chk("t1_c2_addr",  IMEM_addr, 32'h4);
        chk("t1_c2_valid", {31'b0, IF_valid}, 32'd0);
        chk("t5_c2_addr2", w2_addr, 32'h0);
        nxt(); smp();
        chk("t1_c3_addr",  IMEM_addr, 32'h8);
        chk("t1_c3_valid", {31'b0, IF_valid}, 32'd1);
        chk("t1_c3_pc",    IF_PC, 32'h0);
        chk("t1_c3_instr", IF_Instruction, mem_word(32'h0));
        chk("t5_c3_pc2",   w2_pc, 32'hFFFF_FFFC);
        nxt(); smp();
        chk("t1_c4_addr",  IMEM_addr, 32'hC);
        chk("t1_c4_pc",    IF_PC, 32'h4);
        chk("t1_c4_instr", IF_Instruction, mem_word(32'h4));
        chk("t5_c4_pc2",   w2_pc, 32'h0);
        nxt(); smp();
        chk("t1_c5_valid", {31'b0, IF_valid}, 32'd1);
        chk("t1_c5_pc",    IF_PC, 32'h8);

        // 2: decode stalls -> two accepts then hold; release delivers 0,4,8 once
        ID_ready = 1'b0;
        do_reset();
        smp();
        nxt(); smp(); chk("t2_c1_req", {31'b0, IMEM_req}, 32'd1);
        nxt(); smp(); chk("t2_c2_req", {31'b0, IMEM_req}, 32'd1);
        chk("t2_c2_addr", IMEM_addr, 32'h4);
        nxt(); smp();
        chk("t2_c3_req",   {31'b0, IMEM_req}, 32'd0);
        chk("t2_c3_valid", {31'b0, IF_valid}, 32'd1);
        chk("t2_c3_pc",    IF_PC, 32'h0);
        nxt(); smp();
        chk("t2_c4_req",   {31'b0, IMEM_req}, 32'd0);
        chk("t2_c4_pc",    IF_PC, 32'h0);
        chk("t2_c4_instr", IF_Instruction, mem_word(32'h0));
        nxt();
        ID_ready = 1'b1;
        smp();
        chk("t2_c5_pc",   IF_PC, 32'h0);
        chk("t2_c5_req",  {31'b0, IMEM_req}, 32'd1);
        chk("t2_c5_addr", IMEM_addr, 32'h8);
        nxt(); smp(); chk("t2_c6_pc", IF_PC, 32'h4);
        nxt(); smp();
        chk("t2_c7_pc",    IF_PC, 32'h8);
        chk("t2_c7_valid", {31'b0, IF_valid}, 32'd1);
        chk("t2_c7_instr", IF_Instruction, mem_word(32'h8));

        // 3: 2-cycle latency, redirect with both requests outstanding
        lat = 2;
        do_reset();
        smp();
        nxt(); smp(); chk("t3_c1_addr", IMEM_addr, 32'h0);
        nxt(); smp(); chk("t3_c2_addr", IMEM_addr, 32'h4);
        nxt();
        EX_branch_taken  = 1'b1;
        EX_branch_target = 32'h100;
        smp();
        chk("t3_c3_req",   {31'b0, IMEM_req}, 32'd0);
        chk("t3_c3_valid", {31'b0, IF_valid}, 32'd0);
        nxt();
        EX_branch_taken = 1'b0;
        smp();
        chk("t3_c4_req",   {31'b0, IMEM_req}, 32'd0);
        chk("t3_c4_valid", {31'b0, IF_valid}, 32'd0);
        nxt(); smp();
        chk("t3_c5_req",   {31'b0, IMEM_req}, 32'd1);
        chk("t3_c5_addr",  IMEM_addr, 32'h100);
        chk("t3_c5_valid", {31'b0, IF_valid}, 32'd0);
        nxt(); smp();
        chk("t3_c6_addr",  IMEM_addr, 32'h104);
        chk("t3_c6_valid", {31'b0, IF_valid}, 32'd0);
        nxt(); smp();
        chk("t3_c7_req",   {31'b0, IMEM_req}, 32'd0);
        chk("t3_c7_valid", {31'b0, IF_valid}, 32'd0);
        nxt(); smp();
        chk("t3_c8_valid", {31'b0, IF_valid}, 32'd1);
        chk("t3_c8_pc",    IF_PC, 32'h100);
        chk("t3_c8_instr", IF_Instruction, mem_word(32'h100));

        // 4: misaligned target, redirect in the same cycle as a pop
        lat = 1;
        do_reset();
        smp();
        nxt(); smp();
        nxt(); smp();
        nxt();
        EX_branch_taken  = 1'b1;
        EX_branch_target = 32'h0000_0103;
        smp();
        chk("t4_c3_valid", {31'b0, IF_valid}, 32'd1);
        chk("t4_c3_pc",    IF_PC, 32'h0);
        chk("t4_c3_req",   {31'b0, IMEM_req}, 32'd0);
        nxt();
        EX_branch_taken = 1'b0;
        smp();
        chk("t4_c4_req",   {31'b0, IMEM_req}, 32'd1);
        chk("t4_c4_addr",  IMEM_addr, 32'h100);
        chk("t4_c4_valid", {31'b0, IF_valid}, 32'd0);
        nxt(); smp();
        chk("t4_c5_addr",  IMEM_addr, 32'h104);
        chk("t4_c5_valid", {31'b0, IF_valid}, 32'd0);
        nxt(); smp();
        chk("t4_c6_valid", {31'b0, IF_valid}, 32'd1);
        chk("t4_c6_pc",    IF_PC, 32'h100);

        // 6: asynchronous reset pulse between clock edges
        nxt();
        rst = 1'b1;
        rst_epoch++;
        #1;
        chk("t6_async_valid", {31'b0, IF_valid}, 32'd0);
        chk("t6_async_req",   {31'b0, IMEM_req}, 32'd0);
        chk("t6_async_instr", IF_Instruction, 32'h0000_0013);
        chk("t6_async_pc",    IF_PC, 32'h0);
        chk("t6_async_pc2",   w2_pc, 32'hFFFF_FFFC);
        #1;
        rst = 1'b0;
        smp();
        chk("t6_c0_req", {31'b0, IMEM_req}, 32'd0);
        nxt(); smp();
        chk("t6_c1_req",  {31'b0, IMEM_req}, 32'd1);
        chk("t6_c1_addr", IMEM_addr, 32'h0);
        nxt(); smp(); chk("t6_c2_addr", IMEM_addr, 32'h4);
        nxt(); smp();
        chk("t6_c3_valid", {31'b0, IF_valid}, 32'd1);
        chk("t6_c3_pc",    IF_PC, 32'h0);
        chk("t6_c3_instr", IF_Instruction, mem_word(32'h0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
